// File: rtl/axi_lite_register_file_if.sv
// axi_lite_interface: AXI-lite bundle shared by the interconnect and its slaves.
// Master drives the request channels and the response readies; Slave drives the rest.
interface axi_lite_interface #(
  parameter int READ_ADDRESS_WIDTH  = 8,
  parameter int WRITE_ADDRESS_WIDTH = 8,
  parameter int READ_DATA_WIDTH     = 32,
  parameter int WRITE_DATA_WIDTH    = 32
);
  logic [WRITE_ADDRESS_WIDTH-1:0] awaddr;
  logic [2:0]                     awprot;
  logic                           awvalid;
  logic                           awready;
  logic [WRITE_DATA_WIDTH-1:0]    wdata;
  logic [WRITE_DATA_WIDTH/8-1:0]  wstrb;
  logic                           wvalid;
  logic                           wready;
  logic [1:0]                     bresp;
  logic                           bvalid;
  logic                           bready;
  logic [READ_ADDRESS_WIDTH-1:0]  araddr;
  logic [2:0]                     arprot;
  logic                           arvalid;
  logic                           arready;
  logic [READ_DATA_WIDTH-1:0]     rdata;
  logic [1:0]                     rresp;
  logic                           rvalid;
  logic                           rready;

  modport Master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport Slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_register_file.sv
// axi_lite_register_file: AXI-lite slave exposing NUM_REGS registers of DATA_WIDTH bits.
// AW and W are buffered independently, writes merge by byte strobe, registers flagged
// in RO_MASK read back reg_in, and out-of-range or read-only writes answer SLVERR.
// Optional build macro AXI_LITE_REGFILE_PROT_CHECK_EN: accesses with prot[0]=0
// (unprivileged) are refused with SLVERR; without it awprot/arprot are ignored.
module axi_lite_register_file #(
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         ADDR_WIDTH = 8,
  parameter int unsigned         NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  axi_lite_interface.Slave               axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            write_pulse
);
  localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned OFFSET_BITS = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
  localparam int unsigned IDX_WIDTH   = ADDR_WIDTH - OFFSET_BITS;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_held;
  logic                  w_held;
  logic [IDX_WIDTH-1:0]  aw_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic                  awready;
  logic                  wready;
  logic                  commit;
  logic [IDX_WIDTH-1:0]  ar_idx;
  logic [NUM_REGS-1:0]   wr_sel;
  logic                  wr_ok;
  logic                  rd_hit;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  aw_priv;
  logic                  rd_priv;
  logic                  unused_bits;

  assign awready = !aw_held && !bvalid_q;
  assign wready  = !w_held && !bvalid_q;
  assign commit  = aw_held && w_held;
  assign ar_idx  = axi.araddr[ADDR_WIDTH-1:OFFSET_BITS];

  assign axi.awready = awready;
  assign axi.wready  = wready;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.arready = !rvalid_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

  // Low address offset bits and the upper prot bits carry no meaning here.
  assign unused_bits = ^{axi.awprot, axi.arprot, axi.awaddr, axi.araddr};

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_out
      assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end
  endgenerate

`ifdef AXI_LITE_REGFILE_PROT_CHECK_EN
  // Remember the privilege bit of the buffered write address alongside its index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_priv <= 1'b0;
    end else if (!commit && axi.awvalid && awready) begin
      aw_priv <= axi.awprot[0];
    end
  end
  assign rd_priv = axi.arprot[0];
`else
  assign aw_priv = 1'b1;
  assign rd_priv = 1'b1;
`endif

  // Decode the held write index to a writable register and mux read data by live araddr.
  always_comb begin
    wr_sel  = '0;
    rd_hit  = 1'b0;
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx == IDX_WIDTH'(i) && !RO_MASK[i]) begin
        wr_sel[i] = 1'b1;
      end
      if (ar_idx == IDX_WIDTH'(i)) begin
        rd_hit  = 1'b1;
        rd_data = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
      end
    end
  end

  assign wr_ok = (|wr_sel) && aw_priv;
  assign rd_ok = rd_hit && rd_priv;

  // Write path: buffer AW and W separately, commit one edge after both are held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      aw_idx      <= '0;
      w_data      <= '0;
      w_strb      <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      write_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      write_pulse <= '0;
      if (bvalid_q && axi.bready) begin
        bvalid_q <= 1'b0;
      end
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok) begin
          write_pulse <= wr_sel;
          for (int i = 0; i < NUM_REGS; i++) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
              if (wr_sel[i] && w_strb[b]) begin
                regs[i][b*8 +: 8] <= w_data[b*8 +: 8];
              end
            end
          end
        end
      end else begin
        if (axi.awvalid && awready) begin
          aw_held <= 1'b1;
          aw_idx  <= axi.awaddr[ADDR_WIDTH-1:OFFSET_BITS];
        end
        if (axi.wvalid && wready) begin
          w_held <= 1'b1;
          w_data <= axi.wdata;
          w_strb <= axi.wstrb;
        end
      end
    end
  end

  // Read path: register data and response on the AR handshake, hold until rready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (!rvalid_q && axi.arvalid) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_ok ? rd_data : '0;
      rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end
endmodule
